// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: one log-shifter level per stage, valid/ready on both sides.
// Each item carries its own Op, Cnt and tag down the pipe; all stages advance together.
module pipe_shifter #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic [2:0]       Op,
    input  logic [TAG_W-1:0] InTag,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Out,
    output logic [TAG_W-1:0] OutTag,
    output logic             OutZero
);

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_ROR = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                     input logic [2:0] op,
                                                     input int amt);
        case (op)
            OP_ROL:  return (d << amt) | (d >> (WIDTH - amt));
            OP_SLL:  return d << amt;
            OP_ROR:  return (d >> amt) | (d << (WIDTH - amt));
            OP_SRL:  return d >> amt;
            OP_SRA:  return WIDTH'($signed(d) >>> amt);
            default: return d;
        endcase
    endfunction

    logic [CNT_W-1:0]                  vld_q, vld_d;
    logic [CNT_W-1:0][WIDTH-1:0]       data_q, data_d;
    logic [CNT_W-1:0][2:0]             op_q, op_d;
    logic [CNT_W-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0][TAG_W-1:0]       tag_q, tag_d;
    logic                              adv;

    // Stall is global: the whole pipe freezes when the last stage cannot drain.
    assign adv      = !vld_q[CNT_W-1] || OutReady;
    assign InReady  = adv;
    assign OutValid = vld_q[CNT_W-1];
    assign Out      = data_q[CNT_W-1];
    assign OutTag   = tag_q[CNT_W-1];
    assign OutZero  = OutValid && (Out == '0);

    for (genvar k = 0; k < CNT_W; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign vld_d[0]  = InValid;
            assign op_d[0]   = Op;
            assign cnt_d[0]  = Cnt;
            assign tag_d[0]  = InTag;
            assign data_d[0] = Cnt[0] ? shift_stage(In, Op, 1) : In;
        end else begin : g_body
            assign vld_d[k]  = vld_q[k-1];
            assign op_d[k]   = op_q[k-1];
            assign cnt_d[k]  = cnt_q[k-1];
            assign tag_d[k]  = tag_q[k-1];
            assign data_d[k] = cnt_q[k-1][k] ? shift_stage(data_q[k-1], op_q[k-1], 1 << k)
                                             : data_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            data_q <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            tag_q  <= '0;
        end else if (adv) begin
            vld_q  <= vld_d;
            data_q <= data_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            tag_q  <= tag_d;
        end
    end

    // The last stage's Op/Cnt and the already-consumed Cnt bits are carried but never read.
    logic unused_ctrl;
    assign unused_ctrl = ^{op_q[CNT_W-1], cnt_q};

endmodule
